uart_tx_frame_ctrl: RTL and testbench
=====================================

Name: uart_tx_frame_ctrl

Overview:
UART transmit frame sequencer for the fixed-clock domain. It accepts one byte per handshake and latches the frame configuration. It then serialises start, data (LSB first), optional parity and stop bits on tx_o, paced by an external baud tick. Parity is accumulated per data bit by an instance of the team's uart_parity_bit_compute block, which this controller clears, feeds and samples.

Parameters:
DATA_W, 8, width of tx_data_i; maximum data bits per frame
STATE_W, 3, width of the state register

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous reset, active low
rst_i  in  1  synchronous soft reset, active high
baud_tick_i  in  1  one-cycle pulse per bit period, free-running
cfg_data_bits_i  in  2  data length: 0=5, 1=6, 2=7, 3=8 bits
cfg_parity_en_i  in  1  1 = insert parity bit
cfg_parity_mode_i  in  1  0 = odd, 1 = even
cfg_stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
tx_data_i  in  DATA_W  byte to send; unused upper bits ignored
tx_valid_i  in  1  byte available
tx_ready_o  out  1  controller can accept a byte
tx_o  out  1  serial line, idle high
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse when the last stop bit ends

Behaviour:
- Clock and reset: clk_i; arstn_i is asynchronous, active-low.
- Reset values (arstn_i low or rst_i high): state IDLE, tx_o=1, busy_o=0, frame_done_o=0, tx_ready_o=1, parity accumulator cleared.
- rst_i is synchronous and overrides all other inputs. Asserting it mid-frame aborts the frame: tx_o returns to 1 on the next cycle and no frame_done_o pulse is issued.
- Handshake: tx_ready_o = (state==IDLE), combinational. Accept occurs when tx_valid_i & tx_ready_o.
- On accept, the controller latches tx_data_i and all cfg_* inputs into a shadow register. cfg_* changes during a frame have no effect.
- The accept cycle also pulses parity rst_i to clear the accumulator.
- States and transitions (all advances occur on baud_tick_i):
  - IDLE: tx_o=1. On accept, go to ARMED.
  - ARMED: tx_o=1; waits for the next tick so the start bit is full-length. On tick, go to START.
  - START: tx_o=0. On tick, go to DATA with bit index 0.
  - DATA: tx_o = shift[0]. On tick: pulse parity valid_i with data_i=shift[0], shift right, increment the index.
    - If index == data_bits-1, go to PARITY when enabled, else to STOP1.
  - PARITY: tx_o = parity_bit_o of the instance, with mode from the latched cfg. On tick, go to STOP1.
  - STOP1: tx_o=1. On tick, go to STOP2 if two stop bits, else to IDLE with frame_done_o=1.
  - STOP2: tx_o=1. On tick, go to IDLE with frame_done_o=1.
- busy_o=1 in every state except IDLE.
- A tick arriving in the same cycle as accept is ignored. ARMED waits for the following tick.
- Back-to-back frames: IDLE is re-entered on the final tick, so a new accept is possible on the next cycle. The minimum inter-frame gap is therefore one tick wait (ARMED).
- Frame length in ticks, excluding ARMED: 1 + N + P + S.
- tx_o is registered, so the line changes one clk after the tick.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input break_i (1 bit).
  - In IDLE with break_i=1: tx_o=0 and tx_ready_o=0, holding the line in break.
  - Releasing break_i returns tx_o to 1 on the next cycle.
  - break_i is ignored outside IDLE; the current frame completes first.
- Undefined: no port; IDLE always drives tx_o=1.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams (IDLE, ARMED, START, DATA, PARITY, STOP1, STOP2);
  - the cfg_data_bits encoding and a data-bits lookup;
  - the PARITY_ODD=0 / PARITY_EVEN=1 constants.
- One sub-module: uart_parity_bit_compute, instantiated, with:
  - rst_i = soft reset OR accept;
  - valid_i = DATA-state tick;
  - data_i = shift[0];
  - mode_i = latched parity mode.

Test Plan:
- 0x55, 8N1, tick every 16 clk -> tx_o sequence 0,1,0,1,0,1,0,1,0,1. frame_done_o pulses once after 10 ticks following ARMED. tx_ready_o low throughout.
- 0x00, 8 bits, odd parity -> parity bit 1. 0x07, 8 bits, even parity -> parity bit 1. 0x03, even parity -> parity bit 0.
- 0x1F, 5 bits, even parity, 2 stop bits -> line 0,1,1,1,1,1,1,1,1 (start, 5 data, parity 1, two stops). Upper data bits are never driven.
- cfg_parity_mode_i toggled during DATA -> parity bit follows the latched value. Back-to-back valid -> second start bit begins exactly one tick after frame_done_o.
- rst_i asserted at data bit 3 -> next cycle tx_o=1, busy_o=0, no frame_done_o. Next frame of 0xFF with odd parity -> parity bit 1, showing the accumulator was cleared.
- With UART_TX_BREAK_EN: break_i=1 in IDLE -> tx_o=0, tx_ready_o=0. break_i asserted mid-frame -> frame completes normally, then break takes effect.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame controller: state encodings,
// data-length encoding with its last-bit lookup, parity mode constants and the
// latched frame configuration record.
package uart_pkg;

  // State encodings (3-bit)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP1  = 3'd5;
  localparam logic [2:0] S_STOP2  = 3'd6;

  // cfg_data_bits encoding
  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

  // Parity mode
  localparam logic PARITY_ODD  = 1'b0;
  localparam logic PARITY_EVEN = 1'b1;

  // Frame configuration captured at accept time
  typedef struct packed {
    logic [1:0] data_bits;
    logic       parity_en;
    logic       parity_mode;
    logic       stop2;
  } uart_cfg_t;

  // Index of the last data bit for a given data-length code
  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    logic [2:0] idx;
    case (data_bits)
      DBITS_5: idx = 3'd4;
      DBITS_6: idx = 3'd5;
      DBITS_7: idx = 3'd6;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_parity_bit_compute.sv
// Running parity accumulator: XORs each valid data bit and presents the parity
// bit for the selected mode (odd or even). Cleared by rst_i.
module uart_parity_bit_compute
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic arstn_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic data_i,
  input  logic mode_i,
  output logic parity_bit_o
);

  logic acc_q;

  // Accumulate the XOR of the data bits seen since the last clear
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      acc_q <= 1'b0;
    end else if (rst_i) begin
      acc_q <= 1'b0;
    end else if (valid_i) begin
      acc_q <= acc_q ^ data_i;
    end
  end

  // Even parity repeats the XOR of the data; odd parity inverts it
  assign parity_bit_o = (mode_i == PARITY_EVEN) ? acc_q : ~acc_q;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer. Accepts one byte per valid/ready handshake,
// latches it together with the frame configuration and serialises start, data
// (LSB first), optional parity and one or two stop bits, advancing on each
// baud tick. tx_o is registered and follows the state one clock later.
// Optional build macro: UART_TX_BREAK_EN adds break_i, which holds the line
// low while the controller is idle.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned STATE_W = 3
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              rst_i,
  input  logic              baud_tick_i,
  input  logic [1:0]        cfg_data_bits_i,
  input  logic              cfg_parity_en_i,
  input  logic              cfg_parity_mode_i,
  input  logic              cfg_stop_bits_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
`ifdef UART_TX_BREAK_EN
  input  logic              break_i,
`endif
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  typedef enum logic [STATE_W-1:0] {
    IDLE   = STATE_W'(S_IDLE),
    ARMED  = STATE_W'(S_ARMED),
    START  = STATE_W'(S_START),
    DATA   = STATE_W'(S_DATA),
    PARITY = STATE_W'(S_PARITY),
    STOP1  = STATE_W'(S_STOP1),
    STOP2  = STATE_W'(S_STOP2)
  } state_e;

  state_e            state_q;
  logic [2:0]        bit_idx_q;
  logic              tx_q;
  logic              done_q;
  logic [DATA_W-1:0] shift_q;
  uart_cfg_t         cfg_q;

  logic brk;
  logic accept;
  logic data_tick;
  logic last_bit;
  logic parity_bit;

`ifdef UART_TX_BREAK_EN
  assign brk = break_i;
`else
  assign brk = 1'b0;
`endif

  assign tx_ready_o = (state_q == IDLE) & ~brk;
  assign accept     = tx_valid_i & tx_ready_o;
  assign data_tick  = (state_q == DATA) & baud_tick_i;
  assign last_bit   = (bit_idx_q == last_bit_idx(cfg_q.data_bits));

  // Frame sequencer: state, bit index and registered line / done outputs
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else if (rst_i) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= ~brk;
          if (accept) state_q <= ARMED;
        end
        ARMED: begin
          tx_q <= 1'b1;
          if (baud_tick_i) state_q <= START;
        end
        START: begin
          tx_q <= 1'b0;
          if (baud_tick_i) begin
            state_q   <= DATA;
            bit_idx_q <= 3'd0;
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (baud_tick_i) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (last_bit) state_q <= cfg_q.parity_en ? PARITY : STOP1;
          end
        end
        PARITY: begin
          tx_q <= parity_bit;
          if (baud_tick_i) state_q <= STOP1;
        end
        STOP1: begin
          tx_q <= 1'b1;
          if (baud_tick_i) begin
            if (cfg_q.stop2) begin
              state_q <= STOP2;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        STOP2: begin
          tx_q <= 1'b1;
          if (baud_tick_i) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Shadow byte and configuration: loaded on accept, data shifted per data tick
  always_ff @(posedge clk_i) begin
    if (accept) begin
      shift_q <= tx_data_i;
      cfg_q   <= '{data_bits:   cfg_data_bits_i,
                   parity_en:   cfg_parity_en_i,
                   parity_mode: cfg_parity_mode_i,
                   stop2:       cfg_stop_bits_i};
    end else if (data_tick) begin
      shift_q <= shift_q >> 1;
    end
  end

  uart_parity_bit_compute u_parity (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .rst_i        (rst_i | accept),
    .valid_i      (data_tick),
    .data_i       (shift_q[0]),
    .mode_i       (cfg_q.parity_mode),
    .parity_bit_o (parity_bit)
  );

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: a table of frames with their
// expected line patterns, a scoreboard queue consumed by a line monitor that
// samples each bit mid-period, and hand-written reset / break sequences.
`timescale 1ns/1ps
module tb_uart_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] cfg_bits = 2'd3;
  logic       cfg_pen = 1'b0;
  logic       cfg_pmode = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif
  logic       tx_ready;
  logic       tx_line;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int done_tick = 0;
  int ph = 0;
  bit b2b = 1'b0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  bits;
    logic        pen;
    logic        pmode;
    logic        stop2;
    int          len;
    logic [11:0] line;   // bit i = i-th bit on the line, start first
  } vec_t;

  typedef struct {
    int          len;
    logic [11:0] line;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  uart_tx_frame_ctrl dut (
    .clk_i             (clk),
    .arstn_i           (arstn),
    .rst_i             (rst),
    .baud_tick_i       (tick),
    .cfg_data_bits_i   (cfg_bits),
    .cfg_parity_en_i   (cfg_pen),
    .cfg_parity_mode_i (cfg_pmode),
    .cfg_stop_bits_i   (cfg_stop2),
    .tx_data_i         (tx_data),
    .tx_valid_i        (tx_valid),
`ifdef UART_TX_BREAK_EN
    .break_i           (brk),
`endif
    .tx_ready_o        (tx_ready),
    .tx_o              (tx_line),
    .busy_o            (busy),
    .frame_done_o      (done)
  );

  initial forever #5 clk = ~clk;

  // Baud tick: one cycle in sixteen, changed just after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    tick = (ph == 15);
    if (ph == 15) tick_cnt++;
    ph = (ph + 1) % 16;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: on a start edge with a frame pending, sample each bit mid-period
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !tx_line && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (b2b) check("b2b_gap_ticks", tick_cnt - done_tick, 1);
        for (int i = 0; i < e.len; i++) begin
          repeat ((i == 0) ? 7 : 16) @(negedge clk);
          check($sformatf("line_bit%0d", i), tx_line, e.line[i]);
          check($sformatf("busy_ready_bit%0d", i), {busy, tx_ready}, 2'b10);
        end
      end
      prev = tx_line;
    end
  end

  // Hand over one frame, scramble the inputs, and wait for frame_done
  task automatic send(input vec_t v, input bit push);
    int   n;
    int   cyc;
    bit   seen;
    exp_t e;
    cyc = 0;
    while (!tx_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_send", tx_ready, 1'b1);
    if (push) begin
      e.len  = v.len;
      e.line = v.line;
      exp_q.push_back(e);
    end
    tx_data   = v.data;
    cfg_bits  = v.bits;
    cfg_pen   = v.pen;
    cfg_pmode = v.pmode;
    cfg_stop2 = v.stop2;
    tx_valid  = 1'b1;
    @(negedge clk);
    tx_valid  = 1'b0;
    tx_data   = ~v.data;
    cfg_bits  = ~v.bits;
    cfg_pen   = ~v.pen;
    cfg_pmode = ~v.pmode;
    cfg_stop2 = ~v.stop2;
    n = 0;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 1000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (tick) n++;
        @(negedge clk);
        cyc++;
      end
    end
    check("frame_done_seen", seen, 1'b1);
    check("ticks_to_done", n, v.len + 1);
    done_tick = tick_cnt;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    vec_t v;
    int   n;
    int   cyc;
    int   pulses;

    vecs[0] = '{8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 10, 12'({1'b1, 8'h55, 1'b0})};
    vecs[1] = '{8'h00, 2'd3, 1'b1, 1'b0, 1'b0, 11, 12'({1'b1, 1'b1, 8'h00, 1'b0})};
    vecs[2] = '{8'h07, 2'd3, 1'b1, 1'b1, 1'b0, 11, 12'({1'b1, 1'b1, 8'h07, 1'b0})};
    vecs[3] = '{8'h03, 2'd3, 1'b1, 1'b1, 1'b0, 11, 12'({1'b1, 1'b0, 8'h03, 1'b0})};
    vecs[4] = '{8'h1F, 2'd0, 1'b1, 1'b1, 1'b1,  9, 12'({2'b11, 1'b1, 5'h1F, 1'b0})};
    vecs[5] = '{8'hA3, 2'd2, 1'b1, 1'b0, 1'b0, 10, 12'({1'b1, 1'b0, 7'h23, 1'b0})};
    vecs[6] = '{8'h2C, 2'd1, 1'b0, 1'b1, 1'b1,  9, 12'({2'b11, 6'h2C, 1'b0})};
    vecs[7] = '{8'hC4, 2'd3, 1'b0, 1'b0, 1'b1, 11, 12'({2'b11, 8'hC4, 1'b0})};

    // Reset state, during and after asynchronous reset
    repeat (3) @(negedge clk);
    check("rst_tx", tx_line, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_done", done, 1'b0);
    arstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tx", tx_line, 1'b1);
    check("idle_busy", busy, 1'b0);

    // Table frames, sent back to back
    for (int i = 0; i < 8; i++) begin
      b2b = (i > 0);
      send(vecs[i], 1'b1);
    end
    b2b = 1'b0;

    // Soft reset at data bit 3 of 0x07 (odd parity): abort, no done pulse
    repeat (5) @(negedge clk);
    tx_data = 8'h07; cfg_bits = 2'd3; cfg_pen = 1'b1; cfg_pmode = 1'b0; cfg_stop2 = 1'b0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 500) begin
      if (tick) n++;
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_bit3", n, 5);
    repeat (3) @(negedge clk);
    check("abort_line_low", tx_line, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", tx_line, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", tx_ready, 1'b1);
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", pulses, 0);
    check("abort_stays_idle", tx_line, 1'b1);

    // Accumulator cleared: 0xFF with odd parity gives parity 1
    v = '{8'hFF, 2'd3, 1'b1, 1'b0, 1'b0, 11, 12'({1'b1, 1'b1, 8'hFF, 1'b0})};
    send(v, 1'b1);

`ifdef UART_TX_BREAK_EN
    // Break in idle holds the line low and blocks the handshake
    brk = 1'b1;
    #1;
    check("brk_ready", tx_ready, 1'b0);
    @(negedge clk);
    check("brk_tx", tx_line, 1'b0);
    brk = 1'b0;
    @(negedge clk);
    check("brk_release_tx", tx_line, 1'b1);
    check("brk_release_ready", tx_ready, 1'b1);
    // Break raised mid-frame: the frame finishes, then the line breaks
    fork
      send(vecs[3], 1'b1);
      begin
        repeat (60) @(negedge clk);
        brk = 1'b1;
      end
    join
    check("brk_after_frame_tx", tx_line, 1'b0);
    check("brk_after_frame_ready", tx_ready, 1'b0);
    brk = 1'b0;
    @(negedge clk);
    check("brk_end_tx", tx_line, 1'b1);
`endif

    repeat (4) @(negedge clk);
    check("frames_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
